// File: rtl/lm32_tlb_refill.sv
// LM32 MMU refill walker: one-level page-table walk for DTLB/ITLB misses, round-robin shared.
// Optional FETCH watchdog enabled by defining LM32_TLB_REFILL_TIMEOUT_EN.
module lm32_tlb_refill #(
  parameter int page_size     = 4096,
  parameter int pte_valid_bit = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dreq_i,
  input  logic [31:0] dvaddr_i,
  input  logic        ireq_i,
  input  logic [31:0] ivaddr_i,
  input  logic [31:0] ptbr_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_err_i,
  output logic        upd_valid_o,
  output logic        upd_sel_o,
  output logic [31:0] upd_vaddr_o,
  output logic [31:0] upd_paddr_o,
  input  logic        upd_ready_i,
  output logic        dack_o,
  output logic        iack_o,
  output logic        dfault_o,
  output logic        ifault_o,
  output logic        busy_o
);

  localparam int po = $clog2(page_size);

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        sel_q, sel_nxt;
  logic        last_q, last_nxt;
  logic [31:0] vaddr_q, vaddr_nxt;
  logic [31:0] paddr_q, paddr_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic        flush_pend_q, flush_nxt;
  logic        dfault_q, ifault_q;
  logic        lock_q;
  logic        fault;
  logic        discard;
  logic        grant_sel;
  logic [31:0] gvaddr;
  logic [31:0] pte_addr;
  logic        unused_bits;

`ifdef LM32_TLB_REFILL_TIMEOUT_EN
  logic [9:0]  wd_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      wd_cnt_q <= '0;
    else if (state != FETCH)
      wd_cnt_q <= '0;
    else
      wd_cnt_q <= wd_cnt_q + 10'd1;
  end
`endif

  // On a tie the requester not granted last wins.
  assign grant_sel = (dreq_i && ireq_i) ? ~last_q : ireq_i;
  assign gvaddr    = grant_sel ? ivaddr_i : dvaddr_i;
  assign pte_addr  = {ptbr_i[31:2], 2'b00}
                   + {{(po-2){1'b0}}, gvaddr[31:po], 2'b00};
  assign discard   = flush_pend_q | flush_i;

  assign unused_bits = ^{ptbr_i[1:0], gvaddr[po-1:0], mem_data_i[po-1:0]};

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    last_nxt  = last_q;
    vaddr_nxt = vaddr_q;
    paddr_nxt = paddr_q;
    addr_nxt  = addr_q;
    flush_nxt = flush_pend_q;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        flush_nxt = 1'b0;
        // Lockout covers a pulse in flight and the cycle right after one.
        if ((dreq_i || ireq_i) && !flush_i && !lock_q && !dfault_q && !ifault_q) begin
          sel_nxt   = grant_sel;
          last_nxt  = grant_sel;
          vaddr_nxt = {gvaddr[31:po], {po{1'b0}}};
          addr_nxt  = pte_addr;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (mem_err_i) begin
          state_nxt = IDLE;
          fault     = ~discard;
        end else if (mem_ack_i) begin
          if (discard) begin
            state_nxt = IDLE;
          end else if (mem_data_i[pte_valid_bit]) begin
            paddr_nxt = {mem_data_i[31:po], {po{1'b0}}};
            state_nxt = UPDATE;
          end else begin
            fault     = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          // The bus read cannot be abandoned; remember the flush and drop the result.
          if (flush_i)
            flush_nxt = 1'b1;
`ifdef LM32_TLB_REFILL_TIMEOUT_EN
          if (wd_cnt_q == 10'd1023) begin
            state_nxt = IDLE;
            fault     = ~discard;
          end
`endif
        end
      end
      UPDATE: begin
        if (flush_i)
          state_nxt = IDLE;
        else if (upd_ready_i)
          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      vaddr_q      <= '0;
      paddr_q      <= '0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      dfault_q     <= 1'b0;
      ifault_q     <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      sel_q        <= sel_nxt;
      last_q       <= last_nxt;
      vaddr_q      <= vaddr_nxt;
      paddr_q      <= paddr_nxt;
      addr_q       <= addr_nxt;
      flush_pend_q <= flush_nxt;
      dfault_q     <= fault & ~sel_q;
      ifault_q     <= fault & sel_q;
      lock_q       <= (state == DRAIN) | dfault_q | ifault_q;
    end
  end

  assign mem_req_o   = (state == FETCH);
  assign mem_addr_o  = addr_q;
  assign upd_valid_o = (state == UPDATE) && !flush_i;
  assign upd_sel_o   = sel_q;
  assign upd_vaddr_o = vaddr_q;
  assign upd_paddr_o = paddr_q;
  assign dack_o      = (state == DRAIN) && !sel_q;
  assign iack_o      = (state == DRAIN) && sel_q;
  assign dfault_o    = dfault_q;
  assign ifault_o    = ifault_q;
  assign busy_o      = (state != IDLE);

endmodule
